// File: rtl/hdmi_frame_rd_ctrl_if.sv
// Read-side link between the video frame FIFO and hdmi_frame_rd_ctrl.
// The master side (the controller) issues the read strobe. The slave side (the FIFO) returns the fill level and data.
interface hdmi_frame_rd_ctrl_if #(
  parameter int CNT_W  = 12,
  parameter int DATA_W = 16
);
  logic [CNT_W-1:0]  fifo_rd_cnt;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_cnt,
    input  fifo_empty,
    input  fifo_rd_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_cnt,
    output fifo_empty,
    output fifo_rd_data
  );
endinterface

// File: rtl/hdmi_frame_rd_ctrl.sv
// Frame-aligned FIFO read scheduler for the HDMI output path: prefill, vsync-aligned start, geometry/underflow checks.
// Optional underflow event counter is built when HDMI_RD_UFLOW_CNT_EN is defined.
module hdmi_frame_rd_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int PREFILL  = 512,
  parameter int CNT_W    = 12,
  parameter int DATA_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clr_status,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic                 de_in,
  hdmi_frame_rd_ctrl_if.master fifo,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 de_out,
  output logic [DATA_W-1:0]    pix_data,
  output logic                 stream_active,
  output logic                 underflow,
  output logic                 frame_err,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           uflow_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FILL,
    WAIT_VS,
    STREAM
  } state_t;

  localparam logic [CNT_W-1:0] PREFILL_C = CNT_W'(PREFILL);
  localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_END     = CNT_W'(V_ACTIVE);

  state_t           state;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             vs_in_d;
  logic             rd_valid;
  logic             vs_rise;
  logic             frame_good;
  logic             uflow_evt;

  assign vs_rise    = vs_in & ~vs_in_d;
  assign frame_good = (x == '0) && (y == Y_END);
  assign uflow_evt  = (state == STREAM) & ~vs_rise & de_in & fifo.fifo_empty;

  // The read must land in the same cycle as de_in, so the strobe is decoded directly rather than registered.
  assign fifo.fifo_rd_en = de_in & ~fifo.fifo_empty & (state == STREAM) & ~rst;

  // FIFO data arrives one cycle after the strobe, which lines it up with the delayed de_out.
  assign pix_data = rd_valid ? fifo.fifo_rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      vs_in_d       <= 1'b0;
      rd_valid      <= 1'b0;
      hs_out        <= 1'b0;
      vs_out        <= 1'b0;
      de_out        <= 1'b0;
      stream_active <= 1'b0;
      underflow     <= 1'b0;
      frame_err     <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments let the later set in the case below override this clear, so set beats clear.
      vs_in_d  <= vs_in;
      rd_valid <= fifo.fifo_rd_en;
      hs_out   <= hs_in;
      vs_out   <= vs_in;
      de_out   <= de_in;

      if (clr_status) begin
        underflow <= 1'b0;
        frame_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable) state <= WAIT_FILL;
        end

        WAIT_FILL: begin
          if (!enable)                         state <= IDLE;
          else if (fifo.fifo_rd_cnt >= PREFILL_C) state <= WAIT_VS;
        end

        WAIT_VS: begin
          if (!enable) begin
            state <= IDLE;
          end else if (vs_rise) begin
            state         <= STREAM;
            stream_active <= 1'b1;
            x             <= '0;
            y             <= '0;
          end
        end

        STREAM: begin
          if (vs_rise) begin
            x <= '0;
            y <= '0;
            if (frame_good) begin
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              frame_err     <= 1'b1;
              state         <= WAIT_FILL;
              stream_active <= 1'b0;
            end
            // A stop request only takes effect here, at the frame boundary.
            if (!enable) begin
              state         <= IDLE;
              stream_active <= 1'b0;
            end
          end else if (uflow_evt) begin
            underflow     <= 1'b1;
            state         <= WAIT_FILL;
            stream_active <= 1'b0;
          end else if (de_in) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y != '1) y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end

        default: begin
          state         <= IDLE;
          stream_active <= 1'b0;
        end
      endcase
    end
  end

`ifdef HDMI_RD_UFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      uflow_cnt <= '0;
    end else if (uflow_evt) begin
      if (uflow_cnt != 8'hFF) uflow_cnt <= uflow_cnt + 8'd1;
    end else if (clr_status) begin
      uflow_cnt <= '0;
    end
  end
`else
  assign uflow_cnt = '0;
`endif

endmodule

// File: tb/tb_hdmi_frame_rd_ctrl.sv
// Self-checking bench for hdmi_frame_rd_ctrl: directed scenarios plus randomized frames checked against a behavioural model.
module tb_hdmi_frame_rd_ctrl;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int PRE = 16;
  localparam int CW  = 8;
  localparam int DW  = 16;

  localparam int M_OFF  = 0;
  localparam int M_FILL = 1;
  localparam int M_SYNC = 2;
  localparam int M_RUN  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, clr_status, hs_in, vs_in, de_in;
  logic          hs_out, vs_out, de_out, stream_active, underflow, frame_err;
  logic [DW-1:0] pix_data;
  logic [15:0]   frame_cnt;
  logic [7:0]    uflow_cnt;

  hdmi_frame_rd_ctrl_if #(.CNT_W(CW), .DATA_W(DW)) fif ();

  hdmi_frame_rd_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PREFILL(PRE), .CNT_W(CW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .fifo(fif),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .pix_data(pix_data),
    .stream_active(stream_active), .underflow(underflow), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .uflow_cnt(uflow_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Stimulus controls; clr_v and rst_v are one-shot and cleared after each cycle.
  bit en_v, clr_v, rst_v;
  int cnt_v;
  int empty_rate = 0;
  int clr_rate = 0;
  int uf_line = -1, uf_pix = -1;
  bit clr_at_uf = 0;
  int en_off_line = -1;
  int rst_line = -1, rst_pix = -1;

  logic [15:0] mem [4096];
  int env_ptr = 0;
  int reads = 0;

  // Behavioural model: a frame is good when exactly H*V words were read since streaming began.
  int          m_mode, m_pix, m_fc, m_uc, m_ptr;
  bit          m_uf, m_fe, m_hs, m_vs, m_de, m_vsp, m_rdp;
  logic [15:0] m_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_pix = 0; m_fc = 0; m_uc = 0;
    m_uf = 0; m_fe = 0; m_hs = 0; m_vs = 0; m_de = 0; m_vsp = 0; m_rdp = 0;
    m_word = '0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input bit de, input bit emp, input bit mrd);
    bit vr, uf_evt;
    if (rst_v) begin
      model_reset();
      return;
    end
    vr = vs && !m_vsp;
    m_vsp = vs; m_hs = hs; m_vs = vs; m_de = de;
    m_rdp = mrd;
    if (mrd) begin
      m_word = mem[m_ptr % 4096];
      m_ptr++;
    end
    uf_evt = (m_mode == M_RUN) && !vr && de && emp;
    if (clr_v) begin
      m_uf = 0;
      m_fe = 0;
    end
    if (uf_evt) m_uc = (m_uc < 255) ? m_uc + 1 : 255;
    else if (clr_v) m_uc = 0;
    case (m_mode)
      M_OFF:  if (en_v) m_mode = M_FILL;
      M_FILL: if (!en_v) m_mode = M_OFF; else if (cnt_v >= PRE) m_mode = M_SYNC;
      M_SYNC: if (!en_v) m_mode = M_OFF; else if (vr) begin m_mode = M_RUN; m_pix = 0; end
      default: begin
        if (vr) begin
          if (m_pix == H * V) m_fc++;
          else begin m_fe = 1; m_mode = M_FILL; end
          m_pix = 0;
          if (!en_v) m_mode = M_OFF;
        end else if (uf_evt) begin
          m_uf = 1;
          m_mode = M_FILL;
        end else if (de) begin
          m_pix++;
        end
      end
    endcase
  endtask

  task automatic cyc(input bit hs, input bit vs, input bit de, input bit emp);
    bit mrd, dut_rd;
    logic [15:0] exp_pix;
    @(negedge clk);
    rst = rst_v; enable = en_v; clr_status = clr_v;
    hs_in = hs; vs_in = vs; de_in = de;
    fif.fifo_rd_cnt = CW'(cnt_v);
    fif.fifo_empty = emp;
    #1;
    mrd = de && !emp && (m_mode == M_RUN) && !rst_v;
    check("fifo_rd_en", 32'(fif.fifo_rd_en), 32'(mrd));
    dut_rd = fif.fifo_rd_en;
    @(posedge clk);
    if (dut_rd) begin
      fif.fifo_rd_data = mem[env_ptr % 4096];
      env_ptr++;
      reads++;
    end
    model_step(hs, vs, de, emp, mrd);
    clr_v = 0;
    rst_v = 0;
    #1;
    exp_pix = m_rdp ? m_word : 16'h0;
    check("hs_out", 32'(hs_out), 32'(m_hs));
    check("vs_out", 32'(vs_out), 32'(m_vs));
    check("de_out", 32'(de_out), 32'(m_de));
    check("pix_data", 32'(pix_data), 32'(exp_pix));
    check("stream_active", 32'(stream_active), 32'(m_mode == M_RUN));
    check("underflow", 32'(underflow), 32'(m_uf));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fc & 16'hFFFF));
`ifdef HDMI_RD_UFLOW_CNT_EN
    check("uflow_cnt", 32'(uflow_cnt), 32'(m_uc));
`else
    check("uflow_cnt", 32'(uflow_cnt), 32'h0);
`endif
  endtask

  task automatic vsync();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic body(input int lines, input int len);
    bit emp;
    for (int l = 0; l < lines; l++) begin
      if (l == en_off_line) en_v = 0;
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
      for (int p = 0; p < len; p++) begin
        emp = ($urandom_range(0, 999) < empty_rate);
        if ($urandom_range(0, 999) < clr_rate) clr_v = 1;
        if (l == uf_line && p == uf_pix) begin
          emp = 1;
          if (clr_at_uf) clr_v = 1;
        end
        if (l == rst_line && p == rst_pix) begin
          rst_v = 1;
          cnt_v = 5;
        end
        cyc(0, 0, 1, emp);
      end
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  int r0;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    rst = 1; enable = 0; clr_status = 0; hs_in = 0; vs_in = 0; de_in = 0;
    fif.fifo_rd_cnt = '0; fif.fifo_empty = 1'b1; fif.fifo_rd_data = '0;
    model_reset();
    m_ptr = 0;
    en_v = 0; cnt_v = 0;

    // Reset state
    rst_v = 1; cyc(0, 0, 0, 0);
    rst_v = 1; cyc(0, 0, 0, 0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_stream_active", 32'(stream_active), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);

    // Normal start: one full 8x4 frame
    en_v = 1; cnt_v = 40;
    idle(3);
    vsync();
    check("start_stream_active", 32'(stream_active), 32'd1);
    r0 = reads;
    body(4, 8);
    check("normal_reads", 32'(reads - r0), 32'd32);
    vsync();
    check("normal_frame_cnt", 32'(frame_cnt), 32'd1);
    check("normal_frame_err", 32'(frame_err), 32'd0);

    // Underflow at pixel 5 of line 1 (0-based)
    uf_line = 1; uf_pix = 5;
    r0 = reads;
    body(4, 8);
    uf_line = -1; uf_pix = -1;
    check("uf_reads", 32'(reads - r0), 32'd13);
    check("uf_flag", 32'(underflow), 32'd1);
    check("uf_stream_active", 32'(stream_active), 32'd0);
`ifdef HDMI_RD_UFLOW_CNT_EN
    check("uf_count", 32'(uflow_cnt), 32'd1);
`endif

    // Geometry error: 3 lines then vsync
    vsync();
    body(3, 8);
    vsync();
    check("geom_frame_err", 32'(frame_err), 32'd1);
    check("geom_frame_cnt", 32'(frame_cnt), 32'd1);
    check("geom_stream_active", 32'(stream_active), 32'd0);
    r0 = reads;
    body(4, 8);
    check("geom_no_reads", 32'(reads - r0), 32'd0);
    clr_v = 1; idle(1);
    check("clr_frame_err", 32'(frame_err), 32'd0);
    check("clr_underflow", 32'(underflow), 32'd0);

    // Prefill hold
    en_v = 0; vsync();
    check("stop_idle", 32'(stream_active), 32'd0);
    cnt_v = 15; en_v = 1;
    r0 = reads;
    vsync(); body(4, 8); vsync(); body(4, 8);
    check("prefill_no_reads", 32'(reads - r0), 32'd0);
    cnt_v = 16; idle(2);
    vsync();
    check("prefill_start", 32'(stream_active), 32'd1);
    body(4, 8); vsync();
    check("prefill_frame_cnt", 32'(frame_cnt), 32'd2);

    // Stop at boundary
    en_off_line = 2;
    r0 = reads;
    body(4, 8);
    en_off_line = -1;
    check("stop_reads", 32'(reads - r0), 32'd32);
    check("stop_still_streaming", 32'(stream_active), 32'd1);
    vsync();
    check("stop_stream_active", 32'(stream_active), 32'd0);
    check("stop_frame_cnt", 32'(frame_cnt), 32'd3);

    // Clear coincident with a new underflow: set wins
    en_v = 1; cnt_v = 40; idle(3);
    vsync();
    uf_line = 0; uf_pix = 2; clr_at_uf = 1;
    body(4, 8);
    uf_line = -1; uf_pix = -1; clr_at_uf = 0;
    check("set_wins_underflow", 32'(underflow), 32'd1);

    // Reset mid-stream
    vsync();
    rst_line = 1; rst_pix = 3;
    r0 = reads;
    body(4, 8);
    rst_line = -1; rst_pix = -1;
    check("rst_mid_reads", 32'(reads - r0), 32'd11);
    check("rst_mid_frame_cnt", 32'(frame_cnt), 32'd0);
    r0 = reads;
    vsync(); body(4, 8);
    check("rst_mid_no_reads", 32'(reads - r0), 32'd0);
    cnt_v = 40; idle(2);
    vsync();
    check("rst_mid_restart", 32'(stream_active), 32'd1);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      en_v       = ($urandom_range(0, 9) != 0);
      cnt_v      = $urandom_range(0, 40);
      empty_rate = ($urandom_range(0, 3) == 0) ? 20 : 0;
      clr_rate   = ($urandom_range(0, 3) == 0) ? 30 : 0;
      en_off_line = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      vsync();
      body(($urandom_range(0, 3) == 0) ? $urandom_range(3, 5) : 4,
           ($urandom_range(0, 3) == 0) ? $urandom_range(7, 9) : 8);
    end
    en_off_line = -1;
    vsync();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
